onewire_pad_master: RTL

Single-pin 1-Wire bus master bit engine that sits directly upstream of the bidirectional pad buffer. It drives the pad buffer's data input and tristate control and samples its received output. It executes one reset/presence, write-bit or read-bit slot per command and returns one response per command. The bus is open-drain: the engine only drives low or releases, and an external pull-up restores high.

---
 rtl/onewire_pkg.sv | 35 +++
 rtl/onewire_pad_sync.sv | 40 ++++
 rtl/onewire_pad_master.sv | 108 ++++++++++
 3 files changed

// File: rtl/onewire_pkg.sv
// Shared op-codes, FSM states and slot timing constants for the 1-Wire pad master.
// Timing values are in microseconds, measured from the falling edge of a slot.
package onewire_pkg;

   localparam logic [1:0] OP_RESET = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   typedef enum logic [1:0] {StIdle, StLow, StRelease, StDone} state_t;

   localparam logic [9:0] T_RST_LOW    = 10'd480;
   localparam logic [9:0] T_RST_SAMPLE = 10'd550;
   localparam logic [9:0] T_RST_TOTAL  = 10'd960;
   localparam logic [9:0] T_W1_LOW     = 10'd6;
   localparam logic [9:0] T_W0_LOW     = 10'd60;
   localparam logic [9:0] T_RD_LOW     = 10'd6;
   localparam logic [9:0] T_RD_SAMPLE  = 10'd15;
   localparam logic [9:0] T_SLOT       = 10'd70;

   function automatic logic [9:0] low_us(input logic [1:0] op, input logic wbit);
      if (op == OP_RESET) return T_RST_LOW;
      if (op == OP_WRITE) return wbit ? T_W1_LOW : T_W0_LOW;
      return T_RD_LOW;
   endfunction

   function automatic logic [9:0] total_us(input logic [1:0] op);
      return (op == OP_RESET) ? T_RST_TOTAL : T_SLOT;
   endfunction

   function automatic logic [9:0] sample_us(input logic [1:0] op);
      return (op == OP_RESET) ? T_RST_SAMPLE : T_RD_SAMPLE;
   endfunction

endpackage

// File: rtl/onewire_pad_sync.sv
// Two-flop synchronizer for the pad receive path, optionally followed by a 3-sample
// majority filter when ONEWIRE_GLITCH_FILTER_EN is defined. All flops reset to 1 (idle bus).
module onewire_pad_sync (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic dout
);

   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], din};
      end
   end

`ifdef ONEWIRE_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       maj_q;

   // Only one of the three taps can hold a single-cycle glitch, so the vote rejects it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         hist_q <= 2'b11;
         maj_q  <= 1'b1;
      end else begin
         hist_q <= {hist_q[0], sync_q[1]};
         maj_q  <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
      end
   end

   assign dout = maj_q;
`else
   assign dout = sync_q[1];
`endif

endmodule

// File: rtl/onewire_pad_master.sv
// 1-Wire bit engine: one reset/presence, write-bit or read-bit slot per command.
// Build with ONEWIRE_GLITCH_FILTER_EN to add a majority filter on the receive path.
module onewire_pad_master
   import onewire_pkg::*;
#(
   parameter int unsigned CLKS_PER_US = 50
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic [1:0] CMD_OP,
   input  logic       CMD_BIT,
   output logic       RSP_VALID,
   output logic       RSP_BIT,
   output logic       PAD_I,
   output logic       PAD_T,
   input  logic       PAD_O
);

   localparam int unsigned CW = $clog2(CLKS_PER_US);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_US - 1);

   state_t        state_q;
   logic [CW-1:0] cyc_q;
   logic [9:0]    us_q;
   logic [1:0]    op_q;
   logic          bit_q;
   logic          sample_q;
   logic          ready_q;
   logic          rsp_valid_q;
   logic          rsp_bit_q;
   logic          pad_t_q;
   logic          bus;
   logic          low_end;
   logic          total_end;
   logic          sample_now;

   onewire_pad_sync u_sync (
      .clk  (CLK),
      .rstn (RSTN),
      .din  (PAD_O),
      .dout (bus)
   );

   // Phase boundaries are detected on the last cycle of the final microsecond.
   always_comb begin
      low_end    = (us_q == low_us(op_q, bit_q) - 10'd1) && (cyc_q == CYC_LAST);
      total_end  = (us_q == total_us(op_q) - 10'd1) && (cyc_q == CYC_LAST);
      sample_now = (us_q == sample_us(op_q)) && (cyc_q == '0);
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q     <= StIdle;
         cyc_q       <= '0;
         us_q        <= '0;
         op_q        <= OP_RESET;
         bit_q       <= 1'b0;
         sample_q    <= 1'b1;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_bit_q   <= 1'b0;
         pad_t_q     <= 1'b1;
      end else begin
         // Registered outputs trail the state by one edge.
         pad_t_q     <= (state_q != StLow);
         rsp_valid_q <= (state_q == StDone);
         case (state_q)
            StIdle: begin
               if (CMD_VALID && ready_q) begin
                  op_q    <= CMD_OP;
                  bit_q   <= CMD_BIT;
                  cyc_q   <= '0;
                  us_q    <= '0;
                  ready_q <= 1'b0;
                  state_q <= (CMD_OP == OP_RSVD) ? StDone : StLow;
               end
            end
            StLow, StRelease: begin
               if (cyc_q == CYC_LAST) begin
                  cyc_q <= '0;
                  us_q  <= us_q + 10'd1;
               end else begin
                  cyc_q <= cyc_q + 1'b1;
               end
               if (sample_now) sample_q <= bus;
               if (state_q == StLow && low_end) state_q <= StRelease;
               if (state_q == StRelease && total_end) state_q <= StDone;
            end
            StDone: begin
               ready_q   <= 1'b1;
               rsp_bit_q <= (op_q == OP_RESET) ? ~sample_q :
                            (op_q == OP_READ)  ? sample_q  : 1'b0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign CMD_READY = ready_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_BIT   = rsp_bit_q;
   assign PAD_T     = pad_t_q;
   assign PAD_I     = 1'b0;

endmodule
